// File: rtl/aes_key_expander_if.sv
// Key-schedule port bundle between the round-key consumer and aes_key_expander.
// master drives init/key/round and reads keys; slave is the expander.
interface aes_key_expander_if;
  logic         init;
  logic         keylen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;

  modport master (
    output init,
    output keylen,
    output key,
    output round,
    input  round_key,
    input  ready
  );

  modport slave (
    input  init,
    input  keylen,
    input  key,
    input  round,
    output round_key,
    output ready
  );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128/256 key schedule: expands one round key per cycle into key_mem and
// serves any stored key combinationally by round index once ready.
module aes_key_expander (
  input  logic               clk,
  input  logic               rst_n,
  aes_key_expander_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e       state_q;
  logic [127:0] key_mem_q [15];
  logic [3:0]   cnt_q;
  logic [7:0]   rcon_q;
  logic         keylen_q;
  logic         ready_q;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [127:0] prev_key;
  logic [127:0] base_key;
  logic [127:0] next_key;
  logic [31:0]  sub_in;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;
  logic         use_rcon;
  logic         last;

  always_comb begin
    prev_key = key_mem_q[cnt_q - 4'd1];
    base_key = keylen_q ? key_mem_q[cnt_q - 4'd2] : prev_key;
    // AES-256 odd keys take a plain SubWord with no rotation or rcon.
    use_rcon = !keylen_q || !cnt_q[0];
    sub_in   = use_rcon ? {prev_key[23:0], prev_key[31:24]} : prev_key[31:0];
    t        = sub_word(sub_in) ^ (use_rcon ? {rcon_q, 24'h0} : 32'h0);
    n0       = base_key[127:96] ^ t;
    n1       = base_key[95:64] ^ n0;
    n2       = base_key[63:32] ^ n1;
    n3       = base_key[31:0] ^ n2;
    next_key = {n0, n1, n2, n3};
    last     = keylen_q ? (cnt_q == 4'd14) : (cnt_q == 4'd10);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      cnt_q    <= 4'd0;
      rcon_q   <= 8'h00;
      keylen_q <= 1'b0;
      for (int i = 0; i < 15; i++) key_mem_q[i] <= '0;
    end else if (bus.init) begin
      keylen_q     <= bus.keylen;
      ready_q      <= 1'b0;
      key_mem_q[0] <= bus.key[255:128];
      if (bus.keylen) begin
        key_mem_q[1] <= bus.key[127:0];
        cnt_q        <= 4'd2;
      end else begin
        cnt_q <= 4'd1;
      end
      rcon_q  <= 8'h01;
      state_q <= StExpand;
    end else if (state_q == StExpand) begin
      key_mem_q[cnt_q] <= next_key;
      cnt_q            <= cnt_q + 4'd1;
      if (use_rcon) rcon_q <= xtime(rcon_q);
      if (last) begin
        state_q <= StDone;
        ready_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.round_key = '0;
    if (bus.round <= (keylen_q ? 4'd14 : 4'd10)) bus.round_key = key_mem_q[bus.round];
  end

  assign bus.ready = ready_q;

endmodule
